// File: rtl/addsub_pkg.sv
// Shared types for the add/sub accumulator sequencer.
// Commands, saturation limits and FSM state encoding.
package addsub_pkg;

  typedef enum logic [1:0] {
    CMD_ADD   = 2'b00,
    CMD_SUB   = 2'b01,
    CMD_LOAD  = 2'b10,
    CMD_CLEAR = 2'b11
  } cmd_e;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/addsub_acc_sequencer_adder.sv
// 8-bit ripple add/subtract datapath.
// a, b, op (1 = a - b) in; sum and signed ovf out.
module addsub_acc_sequencer_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       op,
  output logic [7:0] sum,
  output logic       ovf
);

  logic [7:0] bx;
  logic [8:0] c;

  always_comb begin
    bx   = b ^ {8{op}};
    c    = '0;
    c[0] = op;
    sum  = '0;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i])
               | (c[i] & (a[i] ^ bx[i]));
    end
    // carry into vs out of the sign bit
    ovf = c[8] ^ c[7];
  end

endmodule

// File: rtl/addsub_acc_sequencer.sv
// Accumulator command sequencer around the ripple adder.
// Ports: clk, rst, in_* cmd handshake, out_* resp handshake, acc_value.
module addsub_acc_sequencer #(
  parameter bit SAT_EN = 1'b0,
  parameter bit STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_cmd,
  input  logic [7:0] in_operand,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_ovf,
  output logic       out_ovf_sticky,
  output logic [7:0] acc_value
);

  import addsub_pkg::*;

  state_e     state_q, state_d;
  cmd_e       cmd_q;
  logic [7:0] opnd_q;
  logic [7:0] acc_q;
  logic [7:0] sum;
  logic       ovf;
  logic [7:0] acc_d;
  logic       ovf_d;
  logic       sticky_d;
  logic       is_sub;

  assign is_sub = (cmd_q == CMD_SUB);

  addsub_acc_sequencer_adder u_adder (
    .a   (acc_q),
    .b   (opnd_q),
    .op  (is_sub),
    .sum (sum),
    .ovf (ovf)
  );

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == ST_IDLE) & ~rst;
    unique case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    acc_d = sum;
    ovf_d = 1'b0;
    unique case (1'b1)
      (cmd_q == CMD_ADD),
      (cmd_q == CMD_SUB): begin
        ovf_d = ovf;
        // wrapped sum sign flips on overflow
        if (SAT_EN && ovf)
          acc_d = sum[7] ? SAT_POS : SAT_NEG;
      end
      (cmd_q == CMD_LOAD):  acc_d = opnd_q;
      (cmd_q == CMD_CLEAR): acc_d = '0;
      default: acc_d = sum;
    endcase
    sticky_d = STICKY ? (out_ovf_sticky | ovf_d)
                      : ovf_d;
    if (cmd_q == CMD_CLEAR) sticky_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cmd_q          <= CMD_ADD;
      opnd_q         <= '0;
      acc_q          <= '0;
      out_data       <= '0;
      out_ovf        <= 1'b0;
      out_ovf_sticky <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && in_valid) begin
        cmd_q  <= cmd_e'(in_cmd);
        opnd_q <= in_operand;
      end
      if (state_q == ST_EXEC) begin
        acc_q          <= acc_d;
        out_data       <= acc_d;
        out_ovf        <= ovf_d;
        out_ovf_sticky <= sticky_d;
      end
    end
  end

  assign out_valid = (state_q == ST_RESP);
  assign acc_value = acc_q;

endmodule

// File: tb/tb_addsub_acc_sequencer.sv
// Bench for addsub_acc_sequencer: wrap (SAT_EN=0) and
// saturating (SAT_EN=1) instances driven in lockstep.
module tb_addsub_acc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b1;
  logic [1:0] in_cmd = 2'b00;
  logic [7:0] in_operand = 8'h00;
  logic       out_ready = 1'b0;

  logic [1:0] rdy, ov, oo, os;
  logic [7:0] od [2];
  logic [7:0] av [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] m_acc [2] = '{8'h00, 8'h00};
  logic       m_st  [2] = '{1'b0, 1'b0};
  logic [7:0] e_data [2];
  logic       e_ovf  [2];
  logic       e_st   [2];
  bit         resp_ok = 1'b0;

  always #5 clk = ~clk;

  addsub_acc_sequencer #(.SAT_EN(1'b0), .STICKY(1'b1)) u_wrap (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy[0]),
    .in_cmd(in_cmd), .in_operand(in_operand),
    .out_valid(ov[0]), .out_ready(out_ready),
    .out_data(od[0]), .out_ovf(oo[0]),
    .out_ovf_sticky(os[0]), .acc_value(av[0])
  );

  addsub_acc_sequencer #(.SAT_EN(1'b1), .STICKY(1'b1)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy[1]),
    .in_cmd(in_cmd), .in_operand(in_operand),
    .out_valid(ov[1]), .out_ready(out_ready),
    .out_data(od[1]), .out_ovf(oo[1]),
    .out_ovf_sticky(os[1]), .acc_value(av[1])
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Signed arithmetic model; instance 1 saturates.
  task automatic model(input logic [1:0] c,
                       input logic [7:0] op);
    for (int k = 0; k < 2; k++) begin
      logic signed [7:0] sa, sb;
      int   r;
      logic v;
      logic [7:0] d;
      sa = m_acc[k];
      sb = op;
      r = 0;
      v = 1'b0;
      d = 8'h00;
      case (c)
        2'd0, 2'd1: begin
          r = (c == 2'd0) ? sa + sb : sa - sb;
          v = (r > 127) || (r < -128);
          d = r[7:0];
          if (k == 1 && v) d = (r > 127) ? 8'h7F : 8'h80;
        end
        2'd2: d = op;
        default: d = 8'h00;
      endcase
      m_st[k]   = (c == 2'd3) ? 1'b0 : (m_st[k] | v);
      m_acc[k]  = d;
      e_data[k] = d;
      e_ovf[k]  = v;
      e_st[k]   = m_st[k];
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (ov[k] && !resp_ok)
          chk("spurious out_valid", {31'd0, ov[k]}, 0);
        else if (ov[k]) begin
          chk("cmp out_data", {24'd0, od[k]}, {24'd0, e_data[k]});
          chk("cmp out_ovf", {31'd0, oo[k]}, {31'd0, e_ovf[k]});
          chk("cmp sticky", {31'd0, os[k]}, {31'd0, e_st[k]});
          chk("cmp acc_value", {24'd0, av[k]}, {24'd0, e_data[k]});
        end else if (!resp_ok)
          chk("idle acc_value", {24'd0, av[k]}, {24'd0, m_acc[k]});
      end
    end
  end

  task automatic accept(input logic [1:0] c,
                        input logic [7:0] op);
    int n = 0;
    @(negedge clk);
    while (rdy !== 2'b11 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait in_ready", {30'd0, rdy}, 32'd3);
    in_valid   = 1'b1;
    in_cmd     = c;
    in_operand = op;
    @(posedge clk);
    model(c, op);
    resp_ok = 1'b1;
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("exec out_valid", {30'd0, ov}, 0);
    chk("exec in_ready", {30'd0, rdy}, 0);
  endtask

  task automatic resp(input int hold,
                      output logic [7:0] d0,
                      output logic [7:0] d1,
                      output logic [1:0] of,
                      output logic [1:0] st);
    @(negedge clk);
    chk("resp out_valid", {30'd0, ov}, 32'd3);
    d0 = od[0];
    d1 = od[1];
    of = oo;
    st = os;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold out_valid", {30'd0, ov}, 32'd3);
      chk("hold data0", {24'd0, od[0]}, {24'd0, d0});
      chk("hold data1", {24'd0, od[1]}, {24'd0, d1});
      chk("hold in_ready", {30'd0, rdy}, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    resp_ok = 1'b0;
    @(negedge clk);
    chk("done out_valid", {30'd0, ov}, 0);
    chk("done in_ready", {30'd0, rdy}, 32'd3);
  endtask

  logic [7:0] d0, d1;
  logic [1:0] of, st;

  initial begin
    // 1: reset held with in_valid high
    repeat (3) begin
      @(negedge clk);
      chk("rst out_valid", {30'd0, ov}, 0);
      chk("rst in_ready", {30'd0, rdy}, 0);
      chk("rst acc0", {24'd0, av[0]}, 0);
      chk("rst acc1", {24'd0, av[1]}, 0);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1 chk("post-rst in_ready", {30'd0, rdy}, 32'd3);

    // 2: LOAD 05, ADD 03
    accept(2'd2, 8'h05); resp(0, d0, d1, of, st);
    accept(2'd0, 8'h03); resp(0, d0, d1, of, st);
    chk("t2 data0", {24'd0, d0}, 32'h08);
    chk("t2 data1", {24'd0, d1}, 32'h08);
    chk("t2 ovf", {30'd0, of}, 0);

    // 3: LOAD 7F, ADD 01
    accept(2'd2, 8'h7F); resp(0, d0, d1, of, st);
    accept(2'd0, 8'h01); resp(0, d0, d1, of, st);
    chk("t3 wrap data", {24'd0, d0}, 32'h80);
    chk("t3 sat data", {24'd0, d1}, 32'h7F);
    chk("t3 ovf", {30'd0, of}, 32'd3);
    chk("t3 sticky", {30'd0, st}, 32'd3);

    // 4: LOAD 80, SUB 01, CLEAR
    accept(2'd2, 8'h80); resp(0, d0, d1, of, st);
    chk("t4 load sticky", {30'd0, st}, 32'd3);
    accept(2'd1, 8'h01); resp(0, d0, d1, of, st);
    chk("t4 wrap data", {24'd0, d0}, 32'h7F);
    chk("t4 sat data", {24'd0, d1}, 32'h80);
    chk("t4 ovf", {30'd0, of}, 32'd3);
    accept(2'd3, 8'h5A); resp(0, d0, d1, of, st);
    chk("t4 clr data0", {24'd0, d0}, 0);
    chk("t4 clr data1", {24'd0, d1}, 0);
    chk("t4 clr sticky", {30'd0, st}, 0);

    // 5: back-pressure with a pending new command
    accept(2'd2, 8'h20); resp(0, d0, d1, of, st);
    accept(2'd0, 8'h22);
    in_valid   = 1'b1;
    in_cmd     = 2'd0;
    in_operand = 8'h55;
    resp(5, d0, d1, of, st);
    chk("t5 data", {24'd0, d0}, 32'h42);
    repeat (3) begin
      @(negedge clk);
      chk("t5 single resp", {30'd0, ov}, 0);
    end
    accept(2'd0, 8'h00); resp(0, d0, d1, of, st);
    chk("t5 acc kept", {24'd0, d1}, 32'h42);

    // negative results and negative overflow
    accept(2'd1, 8'h50); resp(0, d0, d1, of, st);
    chk("neg data", {24'd0, d0}, 32'hF2);
    chk("neg ovf", {30'd0, of}, 0);
    accept(2'd1, 8'h7F); resp(0, d0, d1, of, st);
    chk("negovf wrap", {24'd0, d0}, 32'h73);
    chk("negovf sat", {24'd0, d1}, 32'h80);
    chk("negovf sticky", {30'd0, st}, 32'd3);

    // 6: reset during EXEC
    accept(2'd0, 8'h10);
    rst = 1'b1;
    #1;
    chk("t6 acc0", {24'd0, av[0]}, 0);
    chk("t6 acc1", {24'd0, av[1]}, 0);
    chk("t6 sticky", {30'd0, os}, 0);
    chk("t6 out_valid", {30'd0, ov}, 0);
    chk("t6 in_ready", {30'd0, rdy}, 0);
    @(negedge clk);
    rst = 1'b0;
    resp_ok = 1'b0;
    m_acc = '{8'h00, 8'h00};
    m_st  = '{1'b0, 1'b0};
    repeat (3) begin
      @(negedge clk);
      chk("t6 no resp", {30'd0, ov}, 0);
    end
    accept(2'd2, 8'h33); resp(0, d0, d1, of, st);
    chk("t6 load", {24'd0, d0}, 32'h33);
    chk("t6 load sticky", {30'd0, st}, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
